// File: rtl/c1541_head_ctrl.sv
// c1541_head_ctrl: 1541 half-track stepper tracking, head settle timing and
// track-buffer save/load sequencing with activity write-back and disk-change reload.
module c1541_head_ctrl #(
    parameter int SETTLE_CYC = 2000,
    parameter int HT_INIT    = 36,
    parameter int HT_MAX     = 80
) (
    input  logic       clk_c1541,
    input  logic       reset,
    input  logic       ce,
    input  logic       mtr,
    input  logic [1:0] stp,
    input  logic       act,
    input  logic       buff_we,
    input  logic       disk_change,
    input  logic       busy,
    output logic [6:0] half_track,
    output logic [5:0] track,
    output logic       tr00_sense_n,
    output logic       save_req,
    output logic       load_req,
    output logic       ready,
    output logic       dirty
);
    localparam int CW = SETTLE_CYC > 1 ? $clog2(SETTLE_CYC) : 1;
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_SETTLE    = 3'd1;
    localparam logic [2:0] S_SAVE      = 3'd2;
    localparam logic [2:0] S_SAVE_WAIT = 3'd3;
    localparam logic [2:0] S_LOAD      = 3'd4;
    localparam logic [2:0] S_LOAD_WAIT = 3'd5;
    logic [2:0]    state, state_nx;
    logic [1:0]    stp_r, pos, pos_r;
    logic          act_r, dc_r, dc_pend, step_pend, after_idle;
    logic          step_in, step_out, step, dc_edge, dc_any, step_any, act_fall, settled, wait_st;
    logic [CW-1:0] cnt;
    logic [6:0]    ht_nx;
    // swapping the phase bits turns the inward sequence 0,2,1,3 into a plain 2-bit count
    assign pos          = {stp[0], stp[1]};
    assign pos_r        = {stp_r[0], stp_r[1]};
    assign step_in      = mtr && (pos == pos_r + 2'd1);
    assign step_out     = mtr && (pos == pos_r - 2'd1);
    assign step         = step_in || step_out;
    assign ht_nx        = step_in  ? (half_track == 7'(HT_MAX) ? half_track : half_track + 7'd1) :
                          step_out ? (half_track <= 7'd1 ? half_track : half_track - 7'd1) : half_track;
    assign dc_edge      = disk_change && !dc_r;
    assign act_fall     = act_r && !act;
    assign settled      = cnt == CW'(SETTLE_CYC - 1);
    assign wait_st      = state == S_SAVE_WAIT || state == S_LOAD_WAIT;
    assign dc_any       = dc_pend || dc_edge;
    assign step_any     = step_pend || step;
    assign ready        = state == S_IDLE;
    assign tr00_sense_n = half_track > 7'd1;
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:      state_nx = step ? S_SETTLE : (act_fall && dirty) ? S_SAVE : S_IDLE;
            S_SETTLE:    state_nx = (step || !settled) ? S_SETTLE : (half_track[6:1] == track) ? S_IDLE :
                                    dirty ? S_SAVE : S_LOAD;
            S_SAVE:      state_nx = busy ? S_SAVE_WAIT : S_SAVE;
            S_SAVE_WAIT: state_nx = busy ? S_SAVE_WAIT : (dc_any || !after_idle) ? S_LOAD :
                                    step_any ? S_SETTLE : S_IDLE;
            S_LOAD:      state_nx = (busy && load_req) ? S_LOAD_WAIT : S_LOAD;
            S_LOAD_WAIT: state_nx = busy ? S_LOAD_WAIT : dc_any ? S_LOAD : step_any ? S_SETTLE : S_IDLE;
            default:     state_nx = S_LOAD;
        endcase
        if (dc_edge && !wait_st) state_nx = S_LOAD;
    end
    always_ff @(posedge clk_c1541) begin
        if (reset) begin
            state      <= S_LOAD;
            half_track <= 7'(HT_INIT);
            track      <= 6'(HT_INIT >> 1);
            stp_r      <= 2'd0;
            act_r      <= 1'b0;
            dc_r       <= 1'b0;
            dc_pend    <= 1'b0;
            step_pend  <= 1'b0;
            after_idle <= 1'b0;
            cnt        <= '0;
            dirty      <= 1'b0;
            save_req   <= 1'b0;
            load_req   <= 1'b0;
        end else if (ce) begin
            state      <= state_nx;
            half_track <= ht_nx;
            stp_r      <= stp;
            act_r      <= act;
            dc_r       <= disk_change;
            dc_pend    <= state_nx != S_LOAD && (dc_pend || (dc_edge && wait_st));
            step_pend  <= state_nx != S_SETTLE && (step_pend || (step && state != S_IDLE && state != S_SETTLE));
            cnt        <= (state_nx == S_SETTLE && (state != S_SETTLE || step)) ? '0 : settled ? cnt : cnt + CW'(1);
            dirty      <= (disk_change || (state == S_SAVE && busy)) ? 1'b0 : (dirty || buff_we);
            save_req   <= state_nx == S_SAVE;
            load_req   <= state_nx == S_LOAD;
            if (state_nx == S_LOAD && (state != S_LOAD || dc_edge)) track <= ht_nx[6:1];
            if (state_nx == S_SAVE && state != S_SAVE) after_idle <= state == S_IDLE;
        end
    end
endmodule

// File: tb/tb_c1541_head_ctrl.sv
// tb_c1541_head_ctrl: randomized bench for c1541_head_ctrl; a drive-level model predicts
// save/load requests into a scoreboard that an independent monitor consumes.
module tb_c1541_head_ctrl;
    localparam int SC     = 16;
    localparam int HT_MAX = 80;
    logic       clk_c1541 = 0, reset = 1, ce = 0, mtr = 0, act = 0, buff_we = 0, disk_change = 0, busy = 0;
    logic [1:0] stp = 2'd0;
    logic [6:0] half_track;
    logic [5:0] track;
    logic       tr00_sense_n, save_req, load_req, ready, dirty;
    int         vectors = 0, miscompares = 0;
    bit         gaps = 0, auto_busy = 1;
    int         exp_kind[$], exp_trk[$];
    int         m_ht = 36, m_track = 18, m_pi = 0;
    bit         m_dirty = 0;
    int         seq[4] = '{0, 2, 1, 3};

    c1541_head_ctrl #(.SETTLE_CYC(SC), .HT_INIT(36), .HT_MAX(HT_MAX)) dut (
        .clk_c1541(clk_c1541), .reset(reset), .ce(ce), .mtr(mtr), .stp(stp), .act(act),
        .buff_we(buff_we), .disk_change(disk_change), .busy(busy), .half_track(half_track),
        .track(track), .tr00_sense_n(tr00_sense_n), .save_req(save_req), .load_req(load_req),
        .ready(ready), .dirty(dirty)
    );

    always #5 clk_c1541 = ~clk_c1541;

    task automatic chk(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic push(input int kind, input int trk);
        exp_kind.push_back(kind);
        exp_trk.push_back(trk);
    endtask

    task automatic take(input int kind);
        int ek, et;
        vectors++;
        if (exp_kind.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected %s request at track %0d", kind ? "save" : "load", track);
        end else begin
            ek = exp_kind.pop_front();
            et = exp_trk.pop_front();
            if (ek != kind || et != int'(track) || (save_req && load_req)) begin
                miscompares++;
                $display("FAIL request: got %s track %0d both=%0b, expected %s track %0d",
                         kind ? "save" : "load", track, save_req && load_req, ek ? "save" : "load", et);
            end
        end
    endtask

    // one ce tick, optionally preceded by random ce=0 clocks
    task automatic tick();
        int g;
        g = gaps ? $urandom_range(0, 2) : 0;
        ce = 0;
        repeat (g) begin
            @(posedge clk_c1541);
            #1;
        end
        ce = 1;
        @(posedge clk_c1541);
        #1;
    endtask

    task automatic do_step(input int dir);
        m_pi = (m_pi + dir + 4) % 4;
        stp  = 2'(seq[m_pi]);
        if (mtr && dir != 2) m_ht = dir > 0 ? (m_ht < HT_MAX ? m_ht + 1 : m_ht) : (m_ht > 1 ? m_ht - 1 : m_ht);
        tick();
    endtask

    task automatic model_settle();
        if (m_ht / 2 != m_track) begin
            if (m_dirty) push(1, m_track);
            push(0, m_ht / 2);
            m_track = m_ht / 2;
            m_dirty = 0;
        end
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!(ready === 1'b1 && busy === 1'b0) && n < 4000) begin
            tick();
            n++;
        end
        chk({name, " ready"}, int'(ready), 1);
    endtask

    task automatic check_state(input string name);
        chk({name, " half_track"}, int'(half_track), m_ht);
        chk({name, " track"}, int'(track), m_track);
        chk({name, " dirty"}, int'(dirty), int'(m_dirty));
        chk({name, " tr00_sense_n"}, int'(tr00_sense_n), m_ht > 1 ? 1 : 0);
        chk({name, " ready"}, int'(ready), 1);
    endtask

    task automatic pulse_we();
        buff_we = 1;
        tick();
        buff_we = 0;
        m_dirty = 1;
    endtask

    initial begin
        bit ps, pl;
        ps = 0;
        pl = 0;
        forever begin
            @(negedge clk_c1541);
            if (save_req === 1'b1 && !ps) take(1);
            if (load_req === 1'b1 && !pl) take(0);
            ps = save_req === 1'b1;
            pl = load_req === 1'b1;
        end
    end

    // track-buffer stand-in: accepts a request after a short delay, stays busy a while
    initial forever begin
        @(negedge clk_c1541);
        if (auto_busy && !busy && (save_req === 1'b1 || load_req === 1'b1)) begin
            repeat ($urandom_range(1, 4)) @(posedge clk_c1541);
            #1 busy = 1;
            for (int i = 0; i < 200 && (save_req || load_req); i++) @(negedge clk_c1541);
            repeat ($urandom_range(1, 5)) @(posedge clk_c1541);
            #1 busy = 0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        push(0, 18);
        repeat (3) @(posedge clk_c1541);
        #1;
        chk("reset half_track", int'(half_track), 36);
        chk("reset track", int'(track), 18);
        chk("reset load_req", int'(load_req), 0);
        chk("reset save_req", int'(save_req), 0);
        chk("reset ready", int'(ready), 0);
        chk("reset tr00_sense_n", int'(tr00_sense_n), 1);
        reset = 0;
        wait_ready("init");
        check_state("init");

        mtr = 1;
        do_step(1);
        chk("step latency half_track", int'(half_track), 37);
        chk("step drops ready", int'(ready), 0);
        do_step(1);
        model_settle();
        n = 1;
        while (load_req !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("settle latency", n, SC + 1);
        wait_ready("clean step");
        check_state("clean step");

        pulse_we();
        chk("dirty set", int'(dirty), 1);
        do_step(-1);
        do_step(-1);
        model_settle();
        wait_ready("dirty step");
        check_state("dirty step");

        do_step(1);
        model_settle();
        wait_ready("half step");
        check_state("half step");
        for (int i = 0; i < 3; i++) begin
            do_step(i == 1 ? 1 : -1);
            repeat (SC / 2) tick();
        end
        chk("settle restart", int'(ready), 0);
        model_settle();
        wait_ready("settle restart");
        check_state("settle restart");

        pulse_we();
        act = 1;
        tick();
        push(1, m_track);
        m_dirty = 0;
        act = 0;
        tick();
        wait_ready("act stop");
        check_state("act stop");

        repeat (100) do_step(-1);
        chk("outer stop half_track", int'(half_track), 1);
        chk("outer stop tr00_sense_n", int'(tr00_sense_n), 0);
        model_settle();
        wait_ready("track 0");
        check_state("track 0");
        repeat (90) do_step(1);
        model_settle();
        wait_ready("inner stop");
        check_state("inner stop");
        mtr = 0;
        repeat (5) do_step(-1);
        mtr = 1;
        do_step(2);
        repeat (3) tick();
        check_state("ignored steps");

        auto_busy = 0;
        pulse_we();
        push(1, m_track);
        act = 1;
        tick();
        act = 0;
        tick();
        chk("manual save_req", int'(save_req), 1);
        busy = 1;
        tick();
        chk("save accepted", int'(save_req), 0);
        pulse_we();
        chk("dirty in save_wait", int'(dirty), 1);
        disk_change = 1;
        tick();
        disk_change = 0;
        tick();
        push(0, m_ht / 2);
        m_track = m_ht / 2;
        m_dirty = 0;
        busy = 0;
        auto_busy = 1;
        wait_ready("disk change");
        check_state("disk change");

        auto_busy = 0;
        repeat (4) do_step(-1);
        model_settle();
        n = 0;
        while (load_req !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk("manual load_req", int'(load_req), 1);
        busy = 1;
        tick();
        chk("load accepted", int'(load_req), 0);
        mtr = 0;
        ce = 0;
        reset = 1;
        stp = 2'd0;
        m_pi = 0;
        @(posedge clk_c1541);
        #1;
        chk("mid reset half_track", int'(half_track), 36);
        chk("mid reset track", int'(track), 18);
        chk("mid reset load_req", int'(load_req), 0);
        chk("mid reset save_req", int'(save_req), 0);
        chk("mid reset ready", int'(ready), 0);
        chk("mid reset dirty", int'(dirty), 0);
        chk("mid reset tr00_sense_n", int'(tr00_sense_n), 1);
        m_ht = 36;
        m_track = 18;
        m_dirty = 0;
        push(0, 18);
        busy = 0;
        reset = 0;
        mtr = 1;
        auto_busy = 1;
        wait_ready("after reset");
        check_state("after reset");

        gaps = 1;
        repeat (60) begin
            case ($urandom_range(0, 4))
                0: begin
                    repeat ($urandom_range(1, 4)) begin
                        do_step($urandom_range(0, 1) ? 1 : -1);
                        repeat ($urandom_range(0, 3)) tick();
                    end
                    model_settle();
                    wait_ready("rand steps");
                end
                1: pulse_we();
                2: begin
                    act = 1;
                    tick();
                    if (m_dirty) push(1, m_track);
                    m_dirty = 0;
                    act = 0;
                    tick();
                    wait_ready("rand act");
                end
                3: begin
                    mtr = 0;
                    repeat ($urandom_range(1, 3)) do_step($urandom_range(0, 1) ? 1 : -1);
                    mtr = 1;
                    do_step(2);
                end
                default: begin
                    push(0, m_ht / 2);
                    m_track = m_ht / 2;
                    m_dirty = 0;
                    disk_change = 1;
                    tick();
                    disk_change = 0;
                    tick();
                    wait_ready("rand disk change");
                end
            endcase
            check_state("random");
        end
        repeat (10) tick();
        chk("scoreboard leftover", exp_kind.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
